// File: rtl/pin_reset_if.sv
// Pin-reset bundle between the game controller, the H-bridge driver and the pin sensors.
interface pin_reset_if;
    logic       motor_start;
    logic [2:0] pin_raw;
    logic [2:0] pin_state;
    logic       motor_in1;
    logic       motor_in2;
    logic       motor_pwm;
    logic       busy;
    logic       fault;

    modport master (
        output motor_start,
        output pin_raw,
        input  pin_state,
        input  motor_in1,
        input  motor_in2,
        input  motor_pwm,
        input  busy,
        input  fault
    );

    modport slave (
        input  motor_start,
        input  pin_raw,
        output pin_state,
        output motor_in1,
        output motor_in2,
        output motor_pwm,
        output busy,
        output fault
    );
endinterface

// File: rtl/pin_reset_driver.sv
// Drives the pin-lift H-bridge through PULL/HOLD/BRAKE/RELEASE and debounces the pin sensors.
module pin_reset_driver #(
    parameter int unsigned PWM_PERIOD   = 1000,
    parameter int unsigned PULL_DUTY    = 700,
    parameter int unsigned HOLD_DUTY    = 300,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned PULL_TIMEOUT = 150_000_000,
    parameter int unsigned HOLD_CYC     = 20_000_000,
    parameter int unsigned DEAD_CYC     = 100_000,
    parameter int unsigned RELEASE_CYC  = 30_000_000
) (
    input logic        clk,
    input logic        rst,
    pin_reset_if.slave bus
);
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StPull    = 3'd1;
    localparam logic [2:0] StHold    = 3'd2;
    localparam logic [2:0] StBrake   = 3'd3;
    localparam logic [2:0] StRelease = 3'd4;

    localparam int unsigned TMaxA = (PULL_TIMEOUT > HOLD_CYC) ? PULL_TIMEOUT : HOLD_CYC;
    localparam int unsigned TMaxB = (DEAD_CYC > RELEASE_CYC) ? DEAD_CYC : RELEASE_CYC;
    localparam int unsigned TMax  = (TMaxA > TMaxB) ? TMaxA : TMaxB;
    localparam int unsigned TW    = $clog2(TMax + 1);
    localparam int unsigned PW    = $clog2(PWM_PERIOD + 1);
    localparam int unsigned DW    = $clog2(DEBOUNCE_CYC + 1);

    logic [2:0]    sync1_q, sync2_q, pin_state_q;
    logic [DW-1:0] db_cnt_q [3];
    logic          start_q;
    logic          start_pulse;
    logic [2:0]    state_q, state_d;
    logic          fault_q, fault_d;
    logic [TW-1:0] timer_q;
    logic [PW-1:0] pwm_cnt_q;
    logic [31:0]   duty;
    logic          pwm_q;

    // Sensor path: 2-FF synchroniser, then a per-pin stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            pin_state_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= bus.pin_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == pin_state_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DW'(DEBOUNCE_CYC - 1)) begin
                    db_cnt_q[i]    <= '0;
                    pin_state_q[i] <= sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign start_pulse = bus.motor_start & ~start_q;

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        case (state_q)
            StIdle: begin
                if (start_pulse) begin
                    state_d = StPull;
                    fault_d = 1'b0;
                end
            end
            StPull: begin
                // All-up takes priority over a coincident timeout.
                if (pin_state_q == 3'b111) begin
                    state_d = StHold;
                end else if (timer_q == TW'(PULL_TIMEOUT - 1)) begin
                    state_d = StBrake;
                    fault_d = 1'b1;
                end
            end
            StHold: begin
                if (timer_q >= TW'(HOLD_CYC - 1) && !bus.motor_start) state_d = StBrake;
            end
            StBrake: begin
                if (timer_q == TW'(DEAD_CYC - 1)) state_d = StRelease;
            end
            StRelease: begin
                if (timer_q == TW'(RELEASE_CYC - 1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        duty = '0;
        case (state_q)
            StPull, StRelease: duty = PULL_DUTY;
            StHold:            duty = HOLD_DUTY;
            default:           duty = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q   <= 1'b0;
            state_q   <= StIdle;
            fault_q   <= 1'b0;
            timer_q   <= '0;
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            start_q <= bus.motor_start;
            state_q <= state_d;
            fault_q <= fault_d;
            // Saturate so an indefinitely long HOLD never wraps below HOLD_CYC.
            if (state_d != state_q) timer_q <= '0;
            else if (timer_q != '1) timer_q <= timer_q + 1'b1;
            if (pwm_cnt_q == PW'(PWM_PERIOD - 1)) pwm_cnt_q <= '0;
            else pwm_cnt_q <= pwm_cnt_q + 1'b1;
            pwm_q <= (32'(pwm_cnt_q) < duty);
        end
    end

    assign bus.pin_state = pin_state_q;
    assign bus.motor_in1 = (state_q == StPull) || (state_q == StHold);
    assign bus.motor_in2 = (state_q == StRelease);
    assign bus.motor_pwm = pwm_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.fault     = fault_q;
endmodule
